uart_rx_port: RTL and testbench
===============================

Name: uart_rx_port

Overview:
- 8N1 UART receiver with a small receive FIFO, exposed as a memory-mapped read port on the CPU data bus at byte address 0x002.
- Sits directly upstream of the CPU. It replaces the constant input word that the simulation top currently returns for reads of 0x002.
- The top-level read mux selects this block's rd_data whenever rd_hit is high; otherwise it selects memory data.

Parameters:
- BAUD_DIV, 16, clock cycles per UART bit; must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two and >= 2.
- UART_ADDR, 10'h002, bus byte address of the data register.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; rst=0 sampled at posedge resets the block.
- uart_rx  in  1  asynchronous serial line; idles high.
- mem_addr  in  10  CPU bus byte address.
- mem_wr  in  1  CPU write strobe; writes to this block are ignored.
- rd_data  out  16  registered read data.
- rd_hit  out  1  registered; high in the cycle rd_data carries this block's data.
- rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky; a stop bit was sampled low.

Behaviour:
- Reset values:
  - rd_data=16'hffff, rd_hit=0, rx_count=0, overrun=0, frame_err=0.
  - Synchronizer flops=1, receiver state=IDLE, bit counter=0, FIFO empty.
- Reset mid-frame discards any partial byte.
- uart_rx passes through a 2-flop synchronizer; rxs denotes the synchronized value.
- Receiver FSM:
  - IDLE: on rxs=0, go to START and load the divider with BAUD_DIV/2-1.
  - START: when the divider expires, if rxs=0 go to DATA (divider=BAUD_DIV-1, bit index=0); else return to IDLE (glitch rejected, no flag set).
  - DATA: on each divider expiry, shift rxs in LSB-first. After bit 7, go to STOP.
  - STOP: on divider expiry:
    - rxs=1: push the byte into the FIFO, go to IDLE.
    - rxs=0: discard the byte, set frame_err, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. A line held low never produces bytes.
- Sampling points: mid-bit, nominally (n+0.5)*BAUD_DIV cycles after the start-bit edge, ±1 cycle due to synchronizer latency. A byte is pushed 9.5*BAUD_DIV+3 cycles (±1) after the falling start edge.
- Read decode:
  - match = (mem_addr==UART_ADDR) && !mem_wr.
  - pop_req = match && !match_q, where match_q is match registered. An address held for several cycles therefore pops exactly once. Consecutive reads require an intervening non-matching address.
  - In the cycle after any match, rd_hit=1. rd_data = {8'h00, head byte} if a pop occurred; 16'hffff if the FIFO was empty at pop_req. For held-address cycles after the first, rd_data holds its last value.
  - When match=0: rd_hit=0 next cycle; rd_data holds its last value.
- Push and pop in the same cycle:
  - FIFO empty: push succeeds; the read returns 16'hffff (no bypass).
  - FIFO full: both succeed; no overrun.
- Push with FIFO full and no pop: byte dropped, overrun set.
- overrun and frame_err clear only on reset, unless the optional feature is present.

Optional Feature:
- Macro: UART_RX_STATUS_EN.
- Defined:
  - Adds a status register at UART_ADDR+2, read with the same edge-detected rule as the data register.
  - Read value: {10'b0, rx_count zero-extended to 4 bits, frame_err, overrun}.
  - Reading it clears both sticky flags. A flag event in the same cycle as the clear wins, so the flag stays set.
  - rd_hit also asserts for this address.
- Undefined: UART_ADDR+2 is not decoded (rd_hit=0), and the flags are cleared only by reset.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - UART_EMPTY_WORD = 16'hffff.
  - UART_STATUS_OFFSET = 2.
- Sub-module sync_fifo, parameterized WIDTH and DEPTH:
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, count.
  - Pointers one bit wider than the index; registered dout valid the cycle after pop.

Test Plan:
- Single byte: BAUD_DIV=16; drive 0x41 8N1; after 170 cycles read 0x002 -> next cycle rd_hit=1, rd_data=0x0041. A second read -> 0xffff.
- Empty read: read 0x002 right after reset -> rd_data=0xffff, rd_hit=1, rx_count=0.
- Overrun: send 0x01..0x05 with no reads (FIFO_DEPTH=4) -> rx_count=4, overrun=1. Five reads return 0x0001, 0x0002, 0x0003, 0x0004, 0xffff.
- Framing: send 0x55 with stop bit low, then the line high -> no push, frame_err=1. A following valid 0xAA is received correctly.
- Glitch and held address: pulse uart_rx low for 4 cycles -> no byte. Send 0x33, then hold mem_addr=0x002 for 3 cycles -> exactly one pop: rd_data=0x0033 for all three rd_hit cycles, rx_count 1->0.
- Reset mid-frame: assert rst=0 during DATA -> all outputs at their reset values, no byte pushed. A subsequent 0x7E is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive port.
package uart_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rx_state_t;

  localparam logic [15:0] UART_EMPTY_WORD    = 16'hffff;
  localparam int unsigned UART_STATUS_OFFSET = 2;

endpackage

// File: rtl/uart_rx_port_if.sv
// CPU data-bus read port seen by the UART receiver.
interface uart_rx_port_if;
  logic [9:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] rd_data;
  logic        rd_hit;

  modport master (output mem_addr, output mem_wr, input rd_data, input rd_hit);
  modport slave  (input mem_addr, input mem_wr, output rd_data, output rd_hit);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered read port updated on pop.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      count_o
);

  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] dout_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = dout_q;

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem_q[rd_ptr_q[Aw-1:0]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with receive FIFO behind a memory-mapped read port.
// UART_RX_STATUS_EN adds a flag-clearing status register at UartAddr+2.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int unsigned BaudDiv   = 16,
  parameter int unsigned FifoDepth = 4,
  parameter logic [9:0]  UartAddr  = 10'h002,
  localparam int unsigned Cw       = $clog2(FifoDepth) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          uart_rx_i,
  uart_rx_port_if.slave bus,
  output logic [Cw-1:0] rx_count_o,
  output logic          overrun_o,
  output logic          frame_err_o
);

  localparam int unsigned DivW = $clog2(BaudDiv);
  localparam logic [DivW-1:0] DivFull = DivW'(BaudDiv - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(BaudDiv / 2 - 1);

  logic [1:0]      sync_q;
  rx_state_t       state_q;
  logic [DivW-1:0] div_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            push_q, frame_set_q;
  logic            rxs, div_done;

  assign rxs      = sync_q[1];
  assign div_done = (div_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], uart_rx_i};
      push_q      <= 1'b0;
      frame_set_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_q <= StStart;
            div_q   <= DivHalf;
          end
        end
        StStart: begin
          if (!div_done) begin
            div_q <= div_q - 1'b1;
          end else if (!rxs) begin
            state_q <= StData;
            div_q   <= DivFull;
            bit_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (!div_done) begin
            div_q <= div_q - 1'b1;
          end else begin
            shift_q <= {rxs, shift_q[7:1]};
            div_q   <= DivFull;
            if (bit_q == 3'd7) state_q <= StStop;
            else               bit_q   <= bit_q + 1'b1;
          end
        end
        StStop: begin
          if (!div_done) begin
            div_q <= div_q - 1'b1;
          end else if (rxs) begin
            push_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            frame_set_q <= 1'b1;
            state_q     <= StBreak;
          end
        end
        StBreak: begin
          if (rxs) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [Cw-1:0] fifo_count;
  logic          match_dat, match_dat_q, pop_dat;
  logic          match_sts, sts_req;

  assign match_dat = (bus.mem_addr == UartAddr) && !bus.mem_wr;
  assign pop_dat   = match_dat && !match_dat_q;

  sync_fifo #(
    .Width(8),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_q),
    .pop_i  (pop_dat),
    .din_i  (shift_q),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  logic        rd_hit_q, src_fifo_q, src_fifo_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic [15:0] data_q, data_d, sts_word;
  logic        ovr_set;

`ifdef UART_RX_STATUS_EN
  logic match_sts_q;
  assign match_sts = (bus.mem_addr == UartAddr + 10'(UART_STATUS_OFFSET)) && !bus.mem_wr;
  assign sts_req   = match_sts && !match_sts_q;
  assign sts_word  = {10'b0, 4'(fifo_count), frame_err_q, overrun_q};
  always_ff @(posedge clk_i) begin
    if (!rst_ni) match_sts_q <= 1'b0;
    else         match_sts_q <= match_sts;
  end
`else
  assign match_sts = 1'b0;
  assign sts_req   = 1'b0;
  assign sts_word  = UART_EMPTY_WORD;
`endif

  // A full FIFO is never empty, so pop_dat here always frees a slot.
  assign ovr_set = push_q && fifo_full && !pop_dat;

  always_comb begin
    data_d      = data_q;
    src_fifo_d  = src_fifo_q;
    // Same-cycle set beats the status-read clear.
    overrun_d   = (overrun_q & ~sts_req) | ovr_set;
    frame_err_d = (frame_err_q & ~sts_req) | frame_set_q;
    if (pop_dat) begin
      src_fifo_d = !fifo_empty;
      if (fifo_empty) data_d = UART_EMPTY_WORD;
    end else if (sts_req) begin
      src_fifo_d = 1'b0;
      data_d     = sts_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      match_dat_q <= 1'b0;
      rd_hit_q    <= 1'b0;
      src_fifo_q  <= 1'b0;
      data_q      <= UART_EMPTY_WORD;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      match_dat_q <= match_dat;
      rd_hit_q    <= match_dat | match_sts;
      src_fifo_q  <= src_fifo_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The FIFO output register only changes on a pop, so it holds across held-address cycles.
  assign bus.rd_data = src_fifo_q ? {8'h00, fifo_dout} : data_q;
  assign bus.rd_hit  = rd_hit_q;
  assign rx_count_o  = fifo_count;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Randomized bench for uart_rx_port against a queue-based model of the receive port.
module tb_uart_rx_port;

  localparam int Baud  = 16;
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic [2:0] rx_count;
  logic       overrun, frame_err;

  always #5 clk = ~clk;

  uart_rx_port_if bus ();

  uart_rx_port #(
    .BaudDiv  (Baud),
    .FifoDepth(Depth),
    .UartAddr (10'h002)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .uart_rx_i  (line),
    .bus        (bus),
    .rx_count_o (rx_count),
    .overrun_o  (overrun),
    .frame_err_o(frame_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  q[$];
  bit          m_ovr = 1'b0, m_fe = 1'b0;
  logic [15:0] exp_data = 16'hffff;
  bit          exp_hit = 1'b0;
  bit          busy = 1'b0, chk_en = 1'b0;
  logic [15:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_hit", 32'(bus.rd_hit), 32'(exp_hit));
      chk("rd_data", 32'(bus.rd_data), 32'(exp_data));
      if (!busy) begin
        chk("rx_count", 32'(rx_count), 32'(q.size()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit decodes(input logic [9:0] addr);
`ifdef UART_RX_STATUS_EN
    return (addr == 10'h002) || (addr == 10'h004);
`else
    return addr == 10'h002;
`endif
  endfunction

  task automatic model_pop(input logic [9:0] addr);
    if (addr == 10'h002) begin
      exp_data = (q.size() != 0) ? {8'h00, q.pop_front()} : 16'hffff;
    end else if (decodes(addr)) begin
      exp_data = {10'b0, 4'(q.size()), m_fe, m_ovr};
      m_fe  = 1'b0;
      m_ovr = 1'b0;
    end
  endtask

  task automatic do_read(input logic [9:0] addr, input int n);
    bus.mem_addr = addr;
    bus.mem_wr   = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_cycles(1);
      if (i == 0) model_pop(addr);
      exp_hit = decodes(addr);
      @(negedge clk);
      if (i == 0) last_rd = bus.rd_data;
    end
    bus.mem_addr = 10'h100;
    wait_cycles(1);
    exp_hit = 1'b0;
  endtask

  task automatic do_write();
    bus.mem_addr = 10'h002;
    bus.mem_wr   = 1'b1;
    wait_cycles(2);
    bus.mem_addr = 10'h100;
    bus.mem_wr   = 1'b0;
    wait_cycles(1);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    busy = 1'b1;
    line = 1'b0;
    wait_cycles(Baud);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      wait_cycles(Baud);
    end
    line = stop_ok;
    wait_cycles(Baud);
    line = 1'b1;
    wait_cycles(Baud);
    if (stop_ok) begin
      if (q.size() < Depth) q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    busy = 1'b0;
  endtask

  task automatic glitch();
    busy = 1'b1;
    line = 1'b0;
    wait_cycles(4);
    line = 1'b1;
    wait_cycles(2 * Baud);
    busy = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_ovr [5];
    logic [7:0]  rb;
    exp_ovr[0] = 16'h0001; exp_ovr[1] = 16'h0002; exp_ovr[2] = 16'h0003;
    exp_ovr[3] = 16'h0004; exp_ovr[4] = 16'hffff;
    bus.mem_addr = 10'h100;
    bus.mem_wr   = 1'b0;
    wait_cycles(3);
    chk("reset_rd_data", 32'(bus.rd_data), 32'hffff);
    chk("reset_rd_hit", 32'(bus.rd_hit), 32'h0);
    chk("reset_rx_count", 32'(rx_count), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_cycles(2);
    chk_en = 1'b1;

    do_read(10'h002, 1);
    chk("empty_read", 32'(last_rd), 32'hffff);

    send(8'h41, 1'b1);
    do_read(10'h002, 1);
    chk("single_byte", 32'(last_rd), 32'h0041);
    do_read(10'h002, 1);
    chk("second_read_empty", 32'(last_rd), 32'hffff);

    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    chk("ovr_count", 32'(rx_count), 32'd4);
    chk("ovr_flag", 32'(overrun), 32'h1);
    for (int i = 0; i < 5; i++) begin
      do_read(10'h002, 1);
      chk("ovr_read", 32'(last_rd), 32'(exp_ovr[i]));
    end

    send(8'h55, 1'b0);
    chk("frame_flag", 32'(frame_err), 32'h1);
    chk("frame_no_push", 32'(rx_count), 32'h0);
    send(8'hAA, 1'b1);
    do_read(10'h002, 1);
    chk("after_frame", 32'(last_rd), 32'h00AA);

    glitch();
    chk("glitch_no_byte", 32'(rx_count), 32'h0);
    send(8'h33, 1'b1);
    chk("held_count_before", 32'(rx_count), 32'h1);
    do_read(10'h002, 3);
    chk("held_read", 32'(last_rd), 32'h0033);
    chk("held_count_after", 32'(rx_count), 32'h0);

    send(8'h5C, 1'b1);
    do_write();
    chk("write_ignored", 32'(rx_count), 32'h1);
    do_read(10'h002, 1);
    do_read(10'h004, 1);
`ifdef UART_RX_STATUS_EN
    chk("status_read", 32'(last_rd), 32'h0003);
`else
    chk("status_undecoded", 32'(last_rd), 32'h005C);
`endif

    send(8'h11, 1'b1);
    busy = 1'b1;
    line = 1'b0;
    wait_cycles(Baud);
    for (int i = 0; i < 3; i++) begin
      line = 1'(8'h5A >> i);
      wait_cycles(Baud);
    end
    chk_en = 1'b0;
    rst_n  = 1'b0;
    line   = 1'b1;
    wait_cycles(2);
    chk("midrst_rd_data", 32'(bus.rd_data), 32'hffff);
    chk("midrst_rd_hit", 32'(bus.rd_hit), 32'h0);
    chk("midrst_rx_count", 32'(rx_count), 32'h0);
    chk("midrst_overrun", 32'(overrun), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    q.delete();
    m_ovr    = 1'b0;
    m_fe     = 1'b0;
    exp_data = 16'hffff;
    exp_hit  = 1'b0;
    rst_n    = 1'b1;
    wait_cycles(2 * Baud);
    busy   = 1'b0;
    chk_en = 1'b1;
    send(8'h7E, 1'b1);
    do_read(10'h002, 1);
    chk("after_reset", 32'(last_rd), 32'h007E);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          rb = 8'($urandom);
          send(rb, $urandom_range(0, 7) != 0);
        end
        5, 6: do_read(10'h002, $urandom_range(1, 3));
        7: do_read(($urandom_range(0, 1) != 0) ? 10'h004 : 10'h002, 1);
        8: glitch();
        default: do_write();
      endcase
    end
    while (q.size() != 0) do_read(10'h002, 1);
    do_read(10'h002, 1);
    chk("final_empty", 32'(last_rd), 32'hffff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
